dm_dmi_responder: RTL and testbench

Debug-module-side responder for the Debug Module Interface. It accepts `dmi_req_t` requests from the DTM over a valid/ready handshake and decodes the 7-bit address onto a small DM register bank. It returns one `dmi_resp_t` per accepted request after a configurable latency. Exactly one request may be outstanding at a time; it sits between the DTM request channel and the DM control/SBA logic.

---
 rtl/dm_dmi_responder.sv | 193 +++++++++++++++++++
 tb/tb_dm_dmi_responder.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_dmi_responder.sv
// Debug-module side of the DMI: accepts one request at a time, decodes it onto a
// small DM register bank and returns a registered response after RESP_DELAY cycles.
module dm_dmi_responder #(
    parameter int         RESP_DELAY = 1,
    parameter logic [3:0] DM_VERSION = 4'd2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        dmi_req_valid_i,
    output logic        dmi_req_ready_o,
    input  logic [40:0] dmi_req_i,
    output logic        dmi_resp_valid_o,
    input  logic        dmi_resp_ready_i,
    output logic [33:0] dmi_resp_o,
    output logic        dmactive_o,
    output logic        ndmreset_o,
    output logic        haltreq_o,
    output logic [31:0] sbaddress0_o,
    output logic [31:0] sbdata0_o
);

    // Out-of-range delays are clamped so the 4-bit counter can always hold the load value.
    localparam int         DELAY_EFF = (RESP_DELAY < 1) ? 1 : ((RESP_DELAY > 15) ? 15 : RESP_DELAY);
    localparam logic [3:0] CNT_LOAD  = 4'(DELAY_EFF - 1);

    localparam logic [1:0] OP_NOP   = 2'h0;
    localparam logic [1:0] OP_READ  = 2'h1;
    localparam logic [1:0] OP_WRITE = 2'h2;

    localparam logic [6:0] ADDR_DATA0      = 7'h04;
    localparam logic [6:0] ADDR_DATA1      = 7'h05;
    localparam logic [6:0] ADDR_DMCONTROL  = 7'h10;
    localparam logic [6:0] ADDR_DMSTATUS   = 7'h11;
    localparam logic [6:0] ADDR_SBADDRESS0 = 7'h39;
    localparam logic [6:0] ADDR_SBDATA0    = 7'h3C;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_nxt;

    logic [31:0] r_data0;
    logic [31:0] r_data1;
    logic [31:0] r_sbaddress0;
    logic [31:0] r_sbdata0;
    logic        r_dmactive;
    logic        r_ndmreset;
    logic        r_haltreq;
    logic [33:0] r_resp;

    logic [6:0]  w_addr;
    logic [31:0] w_wdata;
    logic [1:0]  w_op;
    logic        w_accept;
    logic        w_dmctrl_we;
    logic        w_dm_clear;
    logic        w_reg_we;
    logic [31:0] w_rdata;
    logic [33:0] w_resp_nxt;

    assign w_addr  = dmi_req_i[40:34];
    assign w_wdata = dmi_req_i[33:2];
    assign w_op    = dmi_req_i[1:0];

    assign w_accept    = dmi_req_valid_i && (r_state == S_IDLE);
    assign w_dmctrl_we = w_accept && (w_op == OP_WRITE) && (w_addr == ADDR_DMCONTROL);
    assign w_dm_clear  = w_dmctrl_we && !w_wdata[0];
    // Non-dmcontrol writes only take effect while the module is active.
    assign w_reg_we    = w_accept && (w_op == OP_WRITE) && r_dmactive;

    // -------------------------------------------------------------------------
    // Handshake: the request channel is ready only in IDLE and a request is
    // accepted on the edge where valid & ready; the response channel holds
    // valid in RESP until the edge where resp_ready is high.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_cnt_nxt   = CNT_LOAD;
                    w_state_nxt = (DELAY_EFF == 1) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = S_RESP;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            S_RESP: begin
                if (dmi_resp_ready_i) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign dmi_req_ready_o  = (r_state == S_IDLE);
    assign dmi_resp_valid_o = (r_state == S_RESP);

    always_comb begin
        w_rdata = 32'h0;
        case (w_addr)
            ADDR_DATA0:      w_rdata = r_data0;
            ADDR_DATA1:      w_rdata = r_data1;
            ADDR_DMCONTROL:  w_rdata = {r_haltreq, 29'h0, r_ndmreset, r_dmactive};
            ADDR_DMSTATUS:   w_rdata = {24'h0, 1'b1, 3'b000, DM_VERSION};
            ADDR_SBADDRESS0: w_rdata = r_sbaddress0;
            ADDR_SBDATA0:    w_rdata = r_sbdata0;
            default:         w_rdata = 32'h0;
        endcase
    end

    always_comb begin
        w_resp_nxt = 34'h0;
        case (w_op)
            OP_READ:  w_resp_nxt = {w_rdata, 2'h0};
            OP_WRITE: w_resp_nxt = 34'h0;
            OP_NOP:   w_resp_nxt = 34'h0;
            default:  w_resp_nxt = {32'h0, 2'h2};
        endcase
    end

    // The payload is captured at acceptance, so reads see pre-update values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_resp <= 34'h0;
        end else if (w_accept) begin
            r_resp <= w_resp_nxt;
        end
    end

    assign dmi_resp_o = r_resp;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_data0      <= 32'h0;
            r_data1      <= 32'h0;
            r_sbaddress0 <= 32'h0;
            r_sbdata0    <= 32'h0;
            r_dmactive   <= 1'b0;
            r_ndmreset   <= 1'b0;
            r_haltreq    <= 1'b0;
        end else if (w_dm_clear) begin
            r_data0      <= 32'h0;
            r_data1      <= 32'h0;
            r_sbaddress0 <= 32'h0;
            r_sbdata0    <= 32'h0;
            r_dmactive   <= 1'b0;
            r_ndmreset   <= 1'b0;
            r_haltreq    <= 1'b0;
        end else if (w_dmctrl_we) begin
            r_dmactive <= 1'b1;
            r_ndmreset <= w_wdata[1];
            r_haltreq  <= w_wdata[31];
        end else if (w_reg_we) begin
            case (w_addr)
                ADDR_DATA0:      r_data0      <= w_wdata;
                ADDR_DATA1:      r_data1      <= w_wdata;
                ADDR_SBADDRESS0: r_sbaddress0 <= w_wdata;
                ADDR_SBDATA0:    r_sbdata0    <= w_wdata;
                default:         ;
            endcase
        end
    end

    assign dmactive_o   = r_dmactive;
    assign ndmreset_o   = r_ndmreset;
    assign haltreq_o    = r_haltreq;
    assign sbaddress0_o = r_sbaddress0;
    assign sbdata0_o    = r_sbdata0;

endmodule

// File: tb/tb_dm_dmi_responder.sv
// Bench for dm_dmi_responder: two instances (RESP_DELAY 1 and 4) driven by directed
// and random DMI transactions, checked against a register-level reference model.
module tb_dm_dmi_responder;

    logic        clk;
    logic        rst_n;
    logic        req_valid  [2];
    logic [40:0] req        [2];
    logic        resp_ready [2];
    logic        req_ready  [2];
    logic        resp_valid [2];
    logic [33:0] resp       [2];
    logic        act        [2];
    logic        ndm        [2];
    logic        halt       [2];
    logic [31:0] sba        [2];
    logic [31:0] sbd        [2];

    int n_checks;
    int n_errors;

    // reference model state
    logic [31:0] m_data0 [2];
    logic [31:0] m_data1 [2];
    logic [31:0] m_sba   [2];
    logic [31:0] m_sbd   [2];
    logic        m_act   [2];
    logic        m_ndm   [2];
    logic        m_halt  [2];
    logic [33:0] exp_q[$];

    dm_dmi_responder #(.RESP_DELAY(1), .DM_VERSION(4'd2)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n),
        .dmi_req_valid_i(req_valid[0]), .dmi_req_ready_o(req_ready[0]), .dmi_req_i(req[0]),
        .dmi_resp_valid_o(resp_valid[0]), .dmi_resp_ready_i(resp_ready[0]), .dmi_resp_o(resp[0]),
        .dmactive_o(act[0]), .ndmreset_o(ndm[0]), .haltreq_o(halt[0]),
        .sbaddress0_o(sba[0]), .sbdata0_o(sbd[0])
    );

    dm_dmi_responder #(.RESP_DELAY(4), .DM_VERSION(4'd2)) u_dut4 (
        .clk_i(clk), .rst_ni(rst_n),
        .dmi_req_valid_i(req_valid[1]), .dmi_req_ready_o(req_ready[1]), .dmi_req_i(req[1]),
        .dmi_resp_valid_o(resp_valid[1]), .dmi_resp_ready_i(resp_ready[1]), .dmi_resp_o(resp[1]),
        .dmactive_o(act[1]), .ndmreset_o(ndm[1]), .haltreq_o(halt[1]),
        .sbaddress0_o(sba[1]), .sbdata0_o(sbd[1])
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "global timeout");
    end

    function automatic int dly(input int i);
        return (i == 0) ? 1 : 4;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < 2; i++) begin
            m_data0[i] = '0; m_data1[i] = '0; m_sba[i] = '0; m_sbd[i] = '0;
            m_act[i] = 1'b0; m_ndm[i] = 1'b0; m_halt[i] = 1'b0;
        end
        exp_q.delete();
    endtask

    function automatic logic [31:0] m_read(input int i, input logic [6:0] a);
        case (a)
            7'h04:   return m_data0[i];
            7'h05:   return m_data1[i];
            7'h10:   return {m_halt[i], 29'h0, m_ndm[i], m_act[i]};
            7'h11:   return 32'h0000_0082;
            7'h39:   return m_sba[i];
            7'h3C:   return m_sbd[i];
            default: return 32'h0;
        endcase
    endfunction

    task automatic m_apply(input int i, input logic [1:0] op, input logic [6:0] a,
                           input logic [31:0] d, output logic [33:0] r);
        r = '0;
        if (op == 2'h1) begin
            r = {m_read(i, a), 2'h0};
        end else if (op == 2'h3) begin
            r = {32'h0, 2'h2};
        end else if (op == 2'h2) begin
            if (a == 7'h10) begin
                if (!d[0]) begin
                    m_data0[i] = '0; m_data1[i] = '0; m_sba[i] = '0; m_sbd[i] = '0;
                    m_act[i] = 1'b0; m_ndm[i] = 1'b0; m_halt[i] = 1'b0;
                end else begin
                    m_act[i] = 1'b1; m_ndm[i] = d[1]; m_halt[i] = d[31];
                end
            end else if (m_act[i]) begin
                if (a == 7'h04) m_data0[i] = d;
                if (a == 7'h05) m_data1[i] = d;
                if (a == 7'h39) m_sba[i]   = d;
                if (a == 7'h3C) m_sbd[i]   = d;
            end
        end
    endtask

    task automatic check_outs(input int i);
        check("dmactive", act[i], m_act[i]);
        check("ndmreset", ndm[i], m_ndm[i]);
        check("haltreq", halt[i], m_halt[i]);
        check("sbaddress0", sba[i], m_sba[i]);
        check("sbdata0", sbd[i], m_sbd[i]);
    endtask

    // driver: one full request/response transaction; optionally holds a second
    // request valid while busy to prove it is not taken
    task automatic txn(input int i, input logic [1:0] op, input logic [6:0] a,
                       input logic [31:0] d, input int hold, input bit second);
        logic [33:0] e;
        bit ok;
        int lat;
        @(negedge clk);
        req[i] = {a, d, op};
        req_valid[i] = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            if (req_ready[i]) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (!ok) begin
            check("accept_timeout", 0, 1);
            req_valid[i] = 1'b0;
            return;
        end
        @(posedge clk);
        m_apply(i, op, a, d, e);
        exp_q.push_back(e);
        #1;
        if (second) req[i] = {7'h05, 32'($urandom()), 2'h2};
        else req_valid[i] = 1'b0;
        check_outs(i);
        ok = 1'b0;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (resp_valid[i]) begin ok = 1'b1; lat = k; break; end
            check("busy_ready", req_ready[i], 0);
        end
        if (!ok) begin
            check("resp_timeout", 0, 1);
            req_valid[i] = 1'b0;
            void'(exp_q.pop_front());
            return;
        end
        check("latency", lat, dly(i));
        e = exp_q.pop_front();
        check("payload", resp[i], e);
        check("resp_ready_low", req_ready[i], 0);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check("hold_valid", resp_valid[i], 1);
            check("hold_payload", resp[i], e);
            check("hold_ready", req_ready[i], 0);
        end
        resp_ready[i] = 1'b1;
        @(posedge clk); #1;
        resp_ready[i] = 1'b0;
        req_valid[i] = 1'b0;
        check("consumed", resp_valid[i], 0);
        check("bubble_ready", req_ready[i], 1);
        check_outs(i);
    endtask

    // accept a request, then pull reset after wait_edges further edges
    task automatic reset_abort(input int i, input int wait_edges);
        @(negedge clk);
        req[i] = {7'h11, 32'h0, 2'h1};
        req_valid[i] = 1'b1;
        @(posedge clk); #1;
        req_valid[i] = 1'b0;
        for (int k = 0; k < wait_edges; k++) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        check("abort_valid_drop", resp_valid[i], 0);
        m_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            check("abort_no_resp", resp_valid[i], 0);
        end
        check("abort_ready", req_ready[i], 1);
        check_outs(i);
    endtask

    logic [6:0] addr_tbl [8];

    initial begin
        logic [6:0]  a;
        logic [1:0]  op;
        logic [31:0] d;
        int          idx;
        addr_tbl = '{7'h04, 7'h05, 7'h10, 7'h11, 7'h39, 7'h3C, 7'h7F, 7'h00};
        n_checks = 0;
        n_errors = 0;
        m_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            req_valid[i] = 1'b0; req[i] = '0; resp_ready[i] = 1'b0;
        end
        #1;
        for (int i = 0; i < 2; i++) begin
            check("rst_ready", req_ready[i], 1);
            check("rst_resp_valid", resp_valid[i], 0);
            check("rst_resp", resp[i], 0);
            check_outs(i);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // dmstatus and dmcontrol basics
        txn(0, 2'h1, 7'h11, 32'h0, 0, 0);
        txn(0, 2'h2, 7'h10, 32'h8000_0003, 0, 0);
        txn(0, 2'h1, 7'h10, 32'h0, 1, 0);
        txn(0, 2'h2, 7'h10, 32'h0, 0, 0);
        // data/SBA registers and dmactive clear
        txn(0, 2'h2, 7'h10, 32'h1, 0, 0);
        txn(0, 2'h2, 7'h04, 32'hDEAD_BEEF, 0, 0);
        txn(0, 2'h1, 7'h04, 32'h0, 0, 0);
        txn(0, 2'h2, 7'h39, 32'h0000_1000, 0, 0);
        txn(0, 2'h2, 7'h3C, 32'h5555_AAAA, 0, 0);
        txn(0, 2'h2, 7'h10, 32'hFFFF_FFFE, 0, 0);
        txn(0, 2'h1, 7'h04, 32'h0, 0, 0);
        txn(0, 2'h1, 7'h39, 32'h0, 0, 0);
        // writes ignored while inactive
        txn(0, 2'h2, 7'h05, 32'h0000_0ABC, 0, 0);
        txn(0, 2'h1, 7'h05, 32'h0, 0, 0);
        // failed op and unmapped address
        txn(0, 2'h2, 7'h10, 32'h1, 0, 0);
        txn(0, 2'h2, 7'h04, 32'h1234_5678, 0, 0);
        txn(0, 2'h3, 7'h04, 32'hFFFF_FFFF, 0, 0);
        txn(0, 2'h1, 7'h04, 32'h0, 0, 0);
        txn(0, 2'h1, 7'h7F, 32'h0, 0, 0);
        txn(0, 2'h0, 7'h04, 32'h0BAD_0BAD, 0, 1);
        txn(0, 2'h1, 7'h05, 32'h0, 0, 0);
        // delay 4 with held response and a competing request
        txn(1, 2'h2, 7'h10, 32'h1, 0, 0);
        txn(1, 2'h1, 7'h11, 32'h0, 5, 1);
        txn(1, 2'h1, 7'h05, 32'h0, 0, 0);

        // random traffic on both instances
        for (int n = 0; n < 240; n++) begin
            int i;
            i   = n % 2;
            idx = $urandom_range(0, 7);
            a   = (idx == 7) ? 7'($urandom_range(0, 127)) : addr_tbl[idx];
            op  = 2'($urandom_range(0, 3));
            d   = $urandom();
            if (a == 7'h10 && op == 2'h2) d[0] = ($urandom_range(0, 3) != 0);
            txn(i, op, a, d, $urandom_range(0, 3), $urandom_range(0, 3) == 0);
        end

        // reset aborts: in WAIT (delay 4) and in RESP (delay 1)
        txn(1, 2'h2, 7'h10, 32'h8000_0003, 0, 0);
        txn(1, 2'h2, 7'h04, 32'hCAFE_F00D, 0, 0);
        txn(1, 2'h2, 7'h39, 32'h0000_2000, 0, 0);
        reset_abort(1, 1);
        txn(1, 2'h1, 7'h04, 32'h0, 0, 0);
        txn(1, 2'h1, 7'h39, 32'h0, 0, 0);
        txn(0, 2'h2, 7'h10, 32'h1, 0, 0);
        txn(0, 2'h2, 7'h3C, 32'h0000_00FF, 0, 0);
        reset_abort(0, 0);
        txn(0, 2'h1, 7'h3C, 32'h0, 0, 0);
        txn(0, 2'h1, 7'h10, 32'h0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
